// File: rtl/out_buf_drain_if.sv
// out_buf_drain_if: valid/ready stream of drained output-buffer words tagged with unit and buffer index
interface out_buf_drain_if #(
   parameter int UW = 3,
   parameter int BW = 5,
   parameter int W  = 32
);
   logic          valid;
   logic          ready;
   logic          last;
   logic [W-1:0]  dat;
   logic [UW-1:0] unit;
   logic [BW-1:0] buf_idx;
   modport master (output valid, dat, unit, buf_idx, last, input ready);
   modport slave  (input valid, dat, unit, buf_idx, last, output ready);
endinterface

// File: rtl/out_buf_drain_ctrl.sv
// out_buf_drain_ctrl: walks every compute unit / output buffer, reads each word and streams it out
module out_buf_drain_ctrl #(
   parameter int COMPUTE_UNIT_NUM = 8,
   parameter int OUTPUT_BUF_NUM   = 32,
   parameter int OUTPUT_BUF_SIZE  = 32,
   localparam int NW = $clog2(OUTPUT_BUF_NUM + 1),
   localparam int BW = $clog2(OUTPUT_BUF_NUM),
   localparam int UW = $clog2(COMPUTE_UNIT_NUM)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       drain_start_i,
   input  logic [NW-1:0]              drain_buf_num_i,
   output logic                       drain_busy_o,
   output logic                       drain_done_o,
   output logic [BW-1:0]              out_buf_sel_o,
   output logic [UW-1:0]              com_unit_out_buf_sel_o,
   input  logic [OUTPUT_BUF_SIZE-1:0] out_buf_dat_i,
   out_buf_drain_if.master            out_s
);
   typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;
   localparam int EW = OUTPUT_BUF_SIZE + UW + BW + 1;
   state_t        state_q, state_d;
   logic [NW-1:0] n_q, n_in;
   logic [UW-1:0] unit_q, inf_unit_q;
   logic [BW-1:0] buf_q, inf_buf_q;
   logic          inf_q, inf_last_q, rd_ptr_q, wr_ptr_q;
   logic [1:0]    cnt_q;
   logic [EW-1:0] fifo_q [2];
   logic          pop, issue, buf_wrap, rd_last, flush_ok;

   assign n_in     = drain_buf_num_i > NW'(OUTPUT_BUF_NUM) ? NW'(OUTPUT_BUF_NUM) : drain_buf_num_i;
   assign pop      = out_s.valid && out_s.ready;
   // a same-cycle pop frees a slot, which keeps the stream at one beat per cycle
   assign issue    = state_q == READ && (3'(cnt_q) + 3'(inf_q) < 3'd2 + 3'(pop));
   assign buf_wrap = NW'(buf_q) + NW'(1) == n_q;
   assign rd_last  = buf_wrap && unit_q == UW'(COMPUTE_UNIT_NUM - 1);
   assign flush_ok = !inf_q && cnt_q == {1'b0, pop};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = drain_start_i ? (n_in == '0 ? DONE : READ) : IDLE;
         READ:    state_d = issue && rd_last ? FLUSH : READ;
         FLUSH:   state_d = flush_ok ? DONE : FLUSH;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         n_q        <= '0;
         unit_q     <= '0;
         buf_q      <= '0;
         inf_q      <= 1'b0;
         inf_unit_q <= '0;
         inf_buf_q  <= '0;
         inf_last_q <= 1'b0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         cnt_q      <= '0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && drain_start_i)
            n_q <= n_in;
         if (issue) begin
            buf_q  <= buf_wrap ? '0 : buf_q + 1'b1;
            unit_q <= rd_last ? '0 : buf_wrap ? unit_q + 1'b1 : unit_q;
         end
         inf_q      <= issue;
         inf_unit_q <= unit_q;
         inf_buf_q  <= buf_q;
         inf_last_q <= rd_last;
         if (inf_q) begin
            fifo_q[wr_ptr_q] <= {inf_last_q, inf_unit_q, inf_buf_q, out_buf_dat_i};
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop)
            rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + 2'(inf_q) - 2'(pop);
      end
   end

   assign out_s.valid = cnt_q != '0;
   assign {out_s.last, out_s.unit, out_s.buf_idx, out_s.dat} = fifo_q[rd_ptr_q];
   assign out_buf_sel_o          = buf_q;
   assign com_unit_out_buf_sel_o = unit_q;
   assign drain_busy_o           = state_q != IDLE;
   assign drain_done_o           = state_q == DONE;
endmodule

// File: tb/tb_out_buf_drain_ctrl.sv
// tb_out_buf_drain_ctrl: directed checks of drain order, timing, flow control, start filtering and reset
module tb_out_buf_drain_ctrl;
   localparam int CU = 8;
   localparam int BN = 32;
   localparam int W  = 32;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [5:0]    num = '0;
   logic          busy, done;
   logic [4:0]    bsel;
   logic [2:0]    usel;
   logic [W-1:0]  bdat = '0;
   int            n_assert = 0;
   int            n_fail = 0;

   out_buf_drain_if #(.UW(3), .BW(5), .W(W)) s ();

   out_buf_drain_ctrl dut (
      .clk_i                  (clk),
      .rst_i                  (rst),
      .drain_start_i          (start),
      .drain_buf_num_i        (num),
      .drain_busy_o           (busy),
      .drain_done_o           (done),
      .out_buf_sel_o          (bsel),
      .com_unit_out_buf_sel_o (usel),
      .out_buf_dat_i          (bdat),
      .out_s                  (s.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_dat(input int u, input int b);
      return 32'hD000_0000 | 32'(u << 16) | 32'(b << 8) | 32'((u * 7 + b * 3) & 255);
   endfunction

   // output buffer model: registered read, data one cycle after the selects
   always @(posedge clk) bdat <= exp_dat(int'(usel), int'(bsel));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ctl"}, 64'({busy, done, s.valid, s.last}), 64'd0);
      check({tag, "_sel"}, 64'({usel, bsel}), 64'd0);
      check({tag, "_dat"}, 64'({s.unit, s.buf_idx, s.dat}), 64'd0);
   endtask

   task automatic drain(input int n, input int mode, input int stall, input int restart_at, input int rst_at);
      int neff, total, beats, c, first_c, last_c;
      logic            held_v;
      logic [W+8:0]    held;
      neff = n > BN ? BN : n;
      total = CU * neff;
      beats = 0;
      c = 0;
      first_c = -1;
      last_c = -1;
      held_v = 1'b0;
      held = '0;
      num = 6'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      while (c < 3000 && !done) begin
         if (rst_at > 0 && beats == rst_at) begin
            rst = 1'b1;
            #1;
            check_idle_outputs("async_reset");
            tick();
            tick();
            rst = 1'b0;
            tick();
            return;
         end
         s.ready = c < stall ? 1'b0 : mode == 1 ? (c % 2 == 0) : 1'b1;
         if (c == restart_at) begin
            start = 1'b1;
            num = 6'd2;
         end
         if (held_v) begin
            check("stall_valid", 64'(s.valid), 64'd1);
            check("stall_hold", 64'({s.last, s.unit, s.buf_idx, s.dat}), 64'(held));
            held_v = 1'b0;
         end
         if (stall > 0 && c == stall - 1) begin
            check("stall_sel", 64'({usel, bsel}), 64'({3'd0, 5'd2}));
            check("stall_head", 64'({s.valid, s.unit, s.buf_idx}), 64'({1'b1, 3'd0, 5'd0}));
         end
         if (s.valid && s.ready) begin
            if (first_c < 0) first_c = c;
            last_c = c;
            check("beat_tag", 64'({s.unit, s.buf_idx}), 64'({3'(beats / neff), 5'(beats % neff)}));
            check("beat_dat", 64'(s.dat), 64'(exp_dat(beats / neff, beats % neff)));
            check("beat_last", 64'(s.last), 64'(beats == total - 1));
            beats++;
         end else if (s.valid) begin
            held_v = 1'b1;
            held = {s.last, s.unit, s.buf_idx, s.dat};
         end
         tick();
         start = 1'b0;
         c++;
      end
      check("done_seen", 64'(done), 64'd1);
      check("beat_count", 64'(beats), 64'(total));
      if (total == 0) begin
         check("zero_done_time", 64'(c), 64'd0);
         check("zero_no_valid", 64'(first_c), 64'(-1));
      end else begin
         check("done_after_last", 64'(c - last_c), 64'd1);
      end
      if (mode == 0 && stall == 0 && total > 0) begin
         check("first_valid_time", 64'(first_c), 64'd2);
         check("back_to_back", 64'(last_c - first_c), 64'(total - 1));
      end
      start = 1'b1;
      num = 6'd4;
      tick();
      start = 1'b0;
      check("start_at_done_ignored", 64'({busy, s.valid}), 64'd0);
   endtask

   initial begin
      s.ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();
      drain(4, 0, 0, -1, 0);
      drain(32, 1, 0, -1, 0);
      drain(4, 0, 10, -1, 0);
      drain(0, 0, 0, -1, 0);
      drain(32, 0, 0, -1, 0);
      drain(40, 0, 0, -1, 0);
      drain(8, 0, 0, 20, 0);
      drain(4, 0, 0, -1, 10);
      drain(4, 0, 0, -1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
